// File: rtl/chunk_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chunk_read_arbiter_pkg
// Brief    : Shared types and helpers for the two-requester chunk read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package chunk_read_arbiter_pkg;

    localparam int NUM_REQ = 2;
    localparam int CHUNK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } req_state_e;

    typedef struct packed {
        logic owner;
        logic last;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // Width helper that never collapses to zero bits for tiny parameters.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : chunk_read_arbiter_if
// Brief    : Command, memory-data and per-requester chunk streams of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface chunk_read_arbiter_if #(
    parameter int ADDR_W = 27
);
    import chunk_read_arbiter_pkg::*;

    logic               cmd_tvalid;
    logic               cmd_tready;
    logic [ADDR_W-1:0]  cmd_taddr;

    logic               mem_tvalid;
    logic               mem_tready;
    logic [CHUNK_W-1:0] mem_tdata;

    logic               chunk0_tvalid;
    logic               chunk0_tready;
    logic [CHUNK_W-1:0] chunk0_tdata;
    logic               chunk0_tlast;

    logic               chunk1_tvalid;
    logic               chunk1_tready;
    logic [CHUNK_W-1:0] chunk1_tdata;
    logic               chunk1_tlast;

    modport master (
        output cmd_tvalid, cmd_taddr,
        input  cmd_tready,
        input  mem_tvalid, mem_tdata,
        output mem_tready,
        output chunk0_tvalid, chunk0_tdata, chunk0_tlast,
        input  chunk0_tready,
        output chunk1_tvalid, chunk1_tdata, chunk1_tlast,
        input  chunk1_tready
    );

    modport slave (
        input  cmd_tvalid, cmd_taddr,
        output cmd_tready,
        output mem_tvalid, mem_tdata,
        input  mem_tready,
        input  chunk0_tvalid, chunk0_tdata, chunk0_tlast,
        output chunk0_tready,
        input  chunk1_tvalid, chunk1_tdata, chunk1_tlast,
        output chunk1_tready
    );

endinterface
`default_nettype wire

// File: rtl/chunk_read_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tag_fifo
// Brief    : Small synchronous FIFO holding one tag per outstanding burst.
// Revision : 1.0 - initial release
// ============================================================================
module tag_fifo
    import chunk_read_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  wire logic             clk_in,
    input  wire logic             rst_in,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] wdata_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = clog2_min1(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        if (w_push && !w_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (w_pop && !w_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/chunk_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : chunk_read_arbiter
// Brief    : Round-robin burst-read arbiter for two frame readers with tagged
//            in-order data return routed to per-requester chunk streams.
// Revision : 1.0 - initial release
// ============================================================================
module chunk_read_arbiter
    import chunk_read_arbiter_pkg::*;
#(
    parameter int BURST_LEN       = 16,
    parameter int FRAME_CHUNKS    = 4800,
    parameter int ADDR_W          = 27,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire logic               clk_in,
    input  wire logic               rst_in,
    input  wire logic [1:0]         start_in,
    input  wire logic [ADDR_W-1:0]  base_addr0_in,
    input  wire logic [ADDR_W-1:0]  base_addr1_in,
    output logic      [1:0]         busy_out,
    output logic      [1:0]         done_out,
    chunk_read_arbiter_if.master    bus
);

    localparam int FRAME_BURSTS = FRAME_CHUNKS / BURST_LEN;
    localparam int BCNT_W       = clog2_min1(FRAME_BURSTS + 1);
    localparam int BEAT_W       = clog2_min1(BURST_LEN);

    req_state_e          state_q [NUM_REQ];
    req_state_e          state_d [NUM_REQ];
    logic [ADDR_W-1:0]   addr_q  [NUM_REQ];
    logic [ADDR_W-1:0]   addr_d  [NUM_REQ];
    logic [BCNT_W-1:0]   bcnt_q  [NUM_REQ];
    logic [BCNT_W-1:0]   bcnt_d  [NUM_REQ];
    logic [ADDR_W-1:0]   w_base  [NUM_REQ];
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                prio_q, prio_d;
    logic                lock_q, lock_d;
    logic                lock_owner_q, lock_owner_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;

    logic [NUM_REQ-1:0]  w_issuing;
    logic [NUM_REQ-1:0]  w_busy;
    logic                w_grant;
    logic                w_cmd_valid;
    logic                w_cmd_fire;
    logic                w_cmd_last;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_mem_ready;
    logic                w_beat_fire;
    logic                w_final_beat;
    logic                w_frame_end;
    tag_t                w_push_tag;
    tag_t                w_head;
    logic [TAG_W-1:0]    w_head_raw;

    assign w_base[0] = base_addr0_in;
    assign w_base[1] = base_addr1_in;

    always_comb begin
        w_issuing = '0;
        w_busy    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_issuing[i] = (state_q[i] == ST_ISSUE);
            w_busy[i]    = (state_q[i] != ST_IDLE);
        end
    end

    // A command left waiting on cmd_tready keeps its owner even if the other
    // requester starts issuing meanwhile.
    always_comb begin
        w_grant = 1'b0;
        if (lock_q) begin
            w_grant = lock_owner_q;
        end else if (w_issuing[0] && w_issuing[1]) begin
            w_grant = prio_q;
        end else if (w_issuing[1]) begin
            w_grant = 1'b1;
        end
    end

    assign w_cmd_valid      = (|w_issuing) && !w_fifo_full;
    assign w_cmd_fire       = w_cmd_valid && bus.cmd_tready;
    assign w_cmd_last       = (bcnt_q[w_grant] == BCNT_W'(FRAME_BURSTS - 1));
    assign w_push_tag.owner = w_grant;
    assign w_push_tag.last  = w_cmd_last;

    assign bus.cmd_tvalid = w_cmd_valid;
    assign bus.cmd_taddr  = addr_q[w_grant];

    tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push_i  (w_cmd_fire),
        .wdata_i (w_push_tag),
        .pop_i   (w_beat_fire && w_final_beat),
        .rdata_o (w_head_raw),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    assign w_head       = tag_t'(w_head_raw);
    assign w_mem_ready  = !w_fifo_empty &&
                          (w_head.owner ? bus.chunk1_tready : bus.chunk0_tready);
    assign w_beat_fire  = bus.mem_tvalid && w_mem_ready;
    assign w_final_beat = (beat_q == BEAT_W'(BURST_LEN - 1));
    assign w_frame_end  = w_beat_fire && w_final_beat && w_head.last;

    assign bus.mem_tready    = w_mem_ready;
    assign bus.chunk0_tvalid = bus.mem_tvalid && !w_fifo_empty && !w_head.owner;
    assign bus.chunk1_tvalid = bus.mem_tvalid && !w_fifo_empty &&  w_head.owner;
    assign bus.chunk0_tdata  = bus.mem_tdata;
    assign bus.chunk1_tdata  = bus.mem_tdata;
    assign bus.chunk0_tlast  = bus.chunk0_tvalid && w_final_beat && w_head.last;
    assign bus.chunk1_tlast  = bus.chunk1_tvalid && w_final_beat && w_head.last;

    assign busy_out = w_busy;
    assign done_out = done_q;

    always_comb begin
        done_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            state_d[i] = state_q[i];
            addr_d[i]  = addr_q[i];
            bcnt_d[i]  = bcnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (start_in[i]) begin
                        state_d[i] = ST_ISSUE;
                        addr_d[i]  = w_base[i];
                        bcnt_d[i]  = '0;
                    end
                end
                ST_ISSUE: begin
                    if (w_cmd_fire && (w_grant == 1'(i))) begin
                        addr_d[i] = addr_q[i] + ADDR_W'(BURST_LEN);
                        bcnt_d[i] = bcnt_q[i] + 1'b1;
                        if (bcnt_q[i] == BCNT_W'(FRAME_BURSTS - 1)) begin
                            state_d[i] = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_frame_end && (w_head.owner == 1'(i))) begin
                        state_d[i] = ST_IDLE;
                        done_d[i]  = 1'b1;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Priority drops back to requester 0 whenever nothing is in flight so a
    // simultaneous start always serves requester 0 first.
    always_comb begin
        prio_d       = prio_q;
        lock_d       = w_cmd_valid && !bus.cmd_tready;
        lock_owner_d = w_grant;
        beat_d       = beat_q;
        if (w_cmd_fire) begin
            prio_d = ~w_grant;
        end else if (w_busy == '0) begin
            prio_d = 1'b0;
        end
        if (w_beat_fire) begin
            beat_d = w_final_beat ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= ST_IDLE;
                addr_q[i]  <= '0;
                bcnt_q[i]  <= '0;
            end
            done_q       <= '0;
            prio_q       <= 1'b0;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            beat_q       <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= state_d[i];
                addr_q[i]  <= addr_d[i];
                bcnt_q[i]  <= bcnt_d[i];
            end
            done_q       <= done_d;
            prio_q       <= prio_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            beat_q       <= beat_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chunk_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunk_read_arbiter
// Brief    : Directed self-checking bench for chunk_read_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunk_read_arbiter;

    localparam int BL = 4;
    localparam int FC = 8;
    localparam int AW = 27;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [1:0]    start = 2'b00;
    logic [AW-1:0] base0 = '0;
    logic [AW-1:0] base1 = '0;
    logic [1:0]    busy, done;

    logic [1:0]    start_b = 2'b00;
    logic [AW-1:0] base_b0 = '0;
    logic [AW-1:0] base_b1 = '0;
    logic [1:0]    busy_b, done_b;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0]  cmd_log [$];
    int             cmd_cyc [$];
    logic [127:0]   c0_data [$];
    logic [127:0]   c1_data [$];
    logic           c0_last [$];
    logic           c1_last [$];
    int             pend, data_ctr, cyc, done0_cnt, done1_cnt;
    logic           mem_en;

    int exp_c0_both [8] = '{0, 1, 2, 3, 8, 9, 10, 11};
    int exp_c1_both [8] = '{4, 5, 6, 7, 12, 13, 14, 15};

    chunk_read_arbiter_if #(.ADDR_W(AW)) bif ();
    chunk_read_arbiter_if #(.ADDR_W(AW)) bif_b ();

    chunk_read_arbiter #(
        .BURST_LEN(BL), .FRAME_CHUNKS(FC), .ADDR_W(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_in(clk), .rst_in(rst_n), .start_in(start),
        .base_addr0_in(base0), .base_addr1_in(base1),
        .busy_out(busy), .done_out(done), .bus(bif)
    );

    chunk_read_arbiter #(
        .BURST_LEN(BL), .FRAME_CHUNKS(32), .ADDR_W(AW), .MAX_OUTSTANDING(MO)
    ) dut_b (
        .clk_in(clk), .rst_in(rst_n), .start_in(start_b),
        .base_addr0_in(base_b0), .base_addr1_in(base_b1),
        .busy_out(busy_b), .done_out(done_b), .bus(bif_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        cmd_log.delete(); cmd_cyc.delete();
        c0_data.delete(); c1_data.delete();
        c0_last.delete(); c1_last.delete();
        pend = 0; data_ctr = 0; cyc = 0; done0_cnt = 0; done1_cnt = 0;
    endtask

    // Memory model: one burst of sequential data per accepted command, in order.
    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            bif.mem_tvalid = mem_en && (pend > 0);
            bif.mem_tdata  = 128'(data_ctr);
            #1;
            if (bif.cmd_tvalid && bif.cmd_tready) begin
                cmd_log.push_back(bif.cmd_taddr);
                cmd_cyc.push_back(cyc);
                pend += BL;
            end
            if (bif.mem_tvalid && bif.mem_tready) begin
                if (bif.chunk0_tvalid) begin
                    c0_data.push_back(bif.chunk0_tdata);
                    c0_last.push_back(bif.chunk0_tlast);
                end
                if (bif.chunk1_tvalid) begin
                    c1_data.push_back(bif.chunk1_tdata);
                    c1_last.push_back(bif.chunk1_tlast);
                end
                pend--;
                data_ctr++;
            end
            if (done[0]) done0_cnt++;
            if (done[1]) done1_cnt++;
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_single_frame(input logic [AW-1:0] b);
        check("sf_cmd_count", 128'(cmd_log.size()), 128'd2);
        check("sf_cmd0_addr", 128'(cmd_log[0]), 128'(b));
        check("sf_cmd1_addr", 128'(cmd_log[1]), 128'(b + AW'(BL)));
        check("sf_cmd_latency", 128'(cmd_cyc[0]), 128'd0);
        check("sf_c0_count", 128'(c0_data.size()), 128'd8);
        for (int k = 0; k < 8; k++) begin
            check("sf_c0_data", c0_data[k], 128'(k));
            check("sf_c0_last", 128'(c0_last[k]), 128'(k == 7));
        end
        check("sf_c1_count", 128'(c1_data.size()), 128'd0);
        check("sf_done0_pulses", 128'(done0_cnt), 128'd1);
        check("sf_done1_pulses", 128'(done1_cnt), 128'd0);
        check("sf_busy_end", 128'(busy), 128'd0);
    endtask

    initial begin
        int n_cmd;
        mem_en = 1'b1;
        clear_logs();
        bif.cmd_tready = 1'b1; bif.mem_tvalid = 1'b1; bif.mem_tdata = '1;
        bif.chunk0_tready = 1'b1; bif.chunk1_tready = 1'b1;
        bif_b.cmd_tready = 1'b1; bif_b.mem_tvalid = 1'b0; bif_b.mem_tdata = '0;
        bif_b.chunk0_tready = 1'b1; bif_b.chunk1_tready = 1'b1;

        // Reset state, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_outputs", 128'({busy, done, bif.cmd_tvalid, bif.mem_tready,
               bif.chunk0_tvalid, bif.chunk0_tlast, bif.chunk1_tvalid, bif.chunk1_tlast}), 128'd0);
        check("rst_b_cmd_tvalid", 128'(bif_b.cmd_tvalid), 128'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        bif.mem_tvalid = 1'b0;

        // Single frame on requester 0.
        @(posedge clk); #1;
        base0 = AW'('h100); start = 2'b01; #1;
        check("start_cycle_no_cmd", 128'(bif.cmd_tvalid), 128'd0);
        @(posedge clk); #1; start = 2'b00;
        clear_logs(); run_cycles(40);
        check_single_frame(AW'('h100));

        // Outstanding limit with memory data withheld.
        base_b0 = AW'('h40); start_b = 2'b01;
        @(posedge clk); #1; start_b = 2'b00;
        n_cmd = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (bif_b.cmd_tvalid && bif_b.cmd_tready) n_cmd++;
            @(posedge clk); #1;
        end
        #1;
        check("mo_cmd_count", 128'(n_cmd), 128'd4);
        check("mo_cmd_tvalid_low", 128'(bif_b.cmd_tvalid), 128'd0);
        check("mo_busy", 128'(busy_b), 128'd1);
        bif_b.mem_tvalid = 1'b1;
        repeat (4) @(posedge clk);
        #1; bif_b.mem_tvalid = 1'b0; bif_b.cmd_tready = 1'b0; #1;
        check("mo_refill_valid", 128'(bif_b.cmd_tvalid), 128'd1);
        check("mo_refill_addr", 128'(bif_b.cmd_taddr), 128'h50);

        // Both requesters start together.
        @(posedge clk); #1;
        base0 = AW'('h000); base1 = AW'('h800); start = 2'b11;
        @(posedge clk); #1; start = 2'b00;
        clear_logs(); run_cycles(50);
        check("both_cmd_count", 128'(cmd_log.size()), 128'd4);
        check("both_cmd0", 128'(cmd_log[0]), 128'h000);
        check("both_cmd1", 128'(cmd_log[1]), 128'h800);
        check("both_cmd2", 128'(cmd_log[2]), 128'h004);
        check("both_cmd3", 128'(cmd_log[3]), 128'h804);
        check("both_c0_count", 128'(c0_data.size()), 128'd8);
        check("both_c1_count", 128'(c1_data.size()), 128'd8);
        for (int k = 0; k < 8; k++) begin
            check("both_c0_data", c0_data[k], 128'(exp_c0_both[k]));
            check("both_c1_data", c1_data[k], 128'(exp_c1_both[k]));
        end
        check("both_c0_last", 128'({c0_last[3], c0_last[7]}), 128'b01);
        check("both_c1_last", 128'({c1_last[3], c1_last[7]}), 128'b01);
        check("both_done_pulses", 128'({done0_cnt[7:0], done1_cnt[7:0]}), 128'h0101);

        // Command held under backpressure; address wraps past 2^ADDR_W.
        bif.cmd_tready = 1'b0;
        base1 = AW'('h7FFFFFE); base0 = AW'('h200); start = 2'b10;
        @(posedge clk); #1; start = 2'b00;
        for (int k = 0; k < 10; k++) begin
            start = (k == 3) ? 2'b01 : 2'b00;
            #1;
            check("hold_cmd", 128'({bif.cmd_tvalid, bif.cmd_taddr}), 128'({1'b1, 27'h7FFFFFE}));
            @(posedge clk); #1;
        end
        start = 2'b00; bif.cmd_tready = 1'b1;
        clear_logs(); run_cycles(50);
        check("hold_cmd0", 128'(cmd_log[0]), 128'h7FFFFFE);
        check("hold_cmd1", 128'(cmd_log[1]), 128'h200);
        check("hold_cmd2_wrap", 128'(cmd_log[2]), 128'h0000002);
        check("hold_cmd3", 128'(cmd_log[3]), 128'h204);
        check("hold_counts", 128'({c0_data.size(), c1_data.size()}), 128'({32'd8, 32'd8}));
        check("hold_first_c1", c1_data[0], 128'd0);
        check("hold_first_c0", c0_data[0], 128'd4);
        check("hold_done_pulses", 128'({done0_cnt[7:0], done1_cnt[7:0]}), 128'h0101);

        // Downstream stall in the middle of a burst.
        base0 = AW'('h100); start = 2'b01;
        @(posedge clk); #1; start = 2'b00;
        clear_logs(); run_cycles(3);
        bif.chunk0_tready = 1'b0;
        bif.mem_tvalid = 1'b1; bif.mem_tdata = 128'(data_ctr); #1;
        check("stall_mem_tready", 128'(bif.mem_tready), 128'd0);
        check("stall_c0_view", 128'({bif.chunk0_tvalid, bif.chunk0_tdata[7:0]}), 128'h102);
        @(posedge clk); #1;
        run_cycles(5);
        check("stall_frozen_count", 128'(c0_data.size()), 128'd2);
        bif.chunk0_tready = 1'b1;
        run_cycles(30);
        check_single_frame(AW'('h100));

        // Reset in the middle of a frame.
        base0 = AW'('h100); start = 2'b01;
        @(posedge clk); #1; start = 2'b00;
        clear_logs(); run_cycles(4);
        check("mid_rst_delivered", 128'(c0_data.size()), 128'd3);
        rst_n = 1'b0; #1;
        check("mid_rst_outputs", 128'({busy, done, bif.cmd_tvalid, bif.mem_tready,
               bif.chunk0_tvalid, bif.chunk0_tlast, bif.chunk1_tvalid, bif.chunk1_tlast}), 128'd0);
        bif.mem_tvalid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        base0 = AW'('h100); start = 2'b01;
        @(posedge clk); #1; start = 2'b00;
        clear_logs(); run_cycles(40);
        check_single_frame(AW'('h100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
